arb_mux_4to1_n: RTL and testbench
=================================

Name: arb_mux_4to1_n

Overview:
- Registered 4:1 collector for an n-bit bus; the gathering counterpart of the 4-way channel demux.
- Four producer channels, each with a valid/ready handshake, merge into one output channel with a single-entry output register.
- Arbitration is round-robin, or fixed-select when forced by `fix_en`.
- The winning channel index travels with the data, so a downstream 4-way demux can route replies back.

Parameters:
DATA_WIDTH, 64, width of every data channel in bits

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ch_1  input  DATA_WIDTH  input channel 1 data
ch_1_valid  input  1  channel 1 data valid
ch_1_ready  output  1  channel 1 beat accepted this cycle
ch_2 / ch_2_valid / ch_2_ready  as channel 1
ch_3 / ch_3_valid / ch_3_ready  as channel 1
ch_4 / ch_4_valid / ch_4_ready  as channel 1
fix_en  input  1  1 = only channel sel_in is eligible; 0 = round-robin
sel_in  input  2  fixed-mode channel select (00 = ch_1 … 11 = ch_4)
ch_out  output  DATA_WIDTH  registered output data
ch_out_valid  output  1  output register holds a beat
ch_out_ready  input  1  downstream accepts the beat
sel_out  output  2  source index of the beat in ch_out (00 = ch_1 … 11 = ch_4)

Behaviour:
- One clock `clk`. Reset is asynchronous, active-low on `rst_n`.
- Reset values:
  - ch_out = 0, ch_out_valid = 0, sel_out = 2'b00.
  - Round-robin pointer last_grant = 2'b11, so ch_1 has highest priority first.
- Output register is a 2-state FSM:
  - EMPTY (ch_out_valid = 0) and FULL (ch_out_valid = 1).
  - can_accept = !ch_out_valid || ch_out_ready.
- Round-robin mode (fix_en = 0):
  - Candidates are the channels with valid = 1.
  - Priority order is last_grant+1, last_grant+2, last_grant+3, last_grant (mod 4).
  - The grant is combinational from the valids and last_grant.
- Fixed mode (fix_en = 1):
  - Only channel sel_in is a candidate; all others see ready = 0.
  - last_grant is still updated on every accept.
- ch_k_ready = grant_k && can_accept. At most one ready is high per cycle. ready may depend on valid; valid must not depend on ready.
- Accept (ch_k_valid && ch_k_ready) on clock edge:
  - ch_out <= ch_k, sel_out <= k-1, ch_out_valid <= 1, last_grant <= k-1.
- Latency is 1 cycle from accept to ch_out_valid.
- Throughput is 1 beat/cycle while ch_out_ready = 1: a simultaneous output drain and input accept replaces the register contents in the same edge (FULL stays FULL).
- Drain without new accept (FULL, ch_out_ready = 1, no grant): ch_out_valid <= 0. ch_out and sel_out hold their last values.
- Backpressure (FULL, ch_out_ready = 0):
  - ch_out, sel_out and ch_out_valid are held stable.
  - All ch_k_ready = 0.
  - last_grant is unchanged.
- No candidates valid: no state change except the drain above.
- fix_en or sel_in changing while FULL does not affect the registered beat. It affects arbitration from that cycle onward.
- Pointer wrap-around: last_grant = 11 gives priority to ch_1 next.
- Reset mid-operation: the held beat is discarded, outputs return to reset values immediately (asynchronously), and last_grant returns to 11.
- No data is duplicated or dropped: every accepted beat appears on ch_out exactly once with ch_out_valid = 1 until ch_out_ready.

Test Plan:
- Reset:
  - Assert rst_n = 0 mid-stream with ch_out_valid = 1 → ch_out_valid = 0, ch_out = 0, sel_out = 00 without waiting for a clock edge.
  - After release with all four valid → first grant is ch_1.
- Single channel streaming:
  - ch_2_valid = 1 for 8 cycles with data 0x10..0x17, ch_out_ready = 1 → ch_out shows 0x10..0x17 on consecutive cycles, 1 cycle after each accept, sel_out = 01 throughout, no bubbles.
- Round-robin fairness:
  - All four valid continuously, ch_out_ready = 1, data = 0xA1/0xB2/0xC3/0xD4 → sel_out sequence 00, 01, 10, 11, 00, 01.
  - ch_out follows the same order.
- Backpressure:
  - ch_out_ready = 0 for 5 cycles while ch_1 and ch_3 are valid → ch_out and sel_out are stable and all readies are 0.
  - On ch_out_ready = 1 → the held beat drains and the next grant goes to the channel after the held beat's source.
- Fixed mode:
  - fix_en = 1, sel_in = 10, all channels valid → only ch_3_ready pulses and sel_out = 10 on every beat.
  - Switch to fix_en = 0 → the next grant goes to ch_4 (pointer = 10).
- Sparse traffic:
  - Only ch_4 then ch_1 valid on alternating cycles, with ch_out_ready toggling → every beat is observed exactly once, in order, with the correct sel_out.

Source files
------------

// File: rtl/arb_mux_4to1_n.sv
// Registered 4:1 collector: round-robin or fixed-select arbitration of four
// valid/ready producers into a single-entry output register tagged with the source index.
module arb_mux_4to1_n #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ch_1,
  input  logic                  ch_1_valid,
  output logic                  ch_1_ready,
  input  logic [DATA_WIDTH-1:0] ch_2,
  input  logic                  ch_2_valid,
  output logic                  ch_2_ready,
  input  logic [DATA_WIDTH-1:0] ch_3,
  input  logic                  ch_3_valid,
  output logic                  ch_3_ready,
  input  logic [DATA_WIDTH-1:0] ch_4,
  input  logic                  ch_4_valid,
  output logic                  ch_4_ready,
  input  logic                  fix_en,
  input  logic [1:0]            sel_in,
  output logic [DATA_WIDTH-1:0] ch_out,
  output logic                  ch_out_valid,
  input  logic                  ch_out_ready,
  output logic [1:0]            sel_out
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [1:0]            last_grant_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [1:0]            sel_r;

  logic [3:0]            valid_s;
  logic [3:0]            grant_s;
  logic [3:0]            ready_s;
  logic [1:0]            win_idx_s;
  logic [1:0]            scan_idx_s;
  logic                  found_s;
  logic                  can_accept_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] win_data_s;

  assign valid_s      = {ch_4_valid, ch_3_valid, ch_2_valid, ch_1_valid};
  assign can_accept_s = (state_r == EMPTY) || ch_out_ready;
  assign accept_s     = |ready_s;

  // Grant selection: fixed channel, or first valid after last_grant in circular order
  always_comb begin
    grant_s    = 4'b0000;
    win_idx_s  = 2'b00;
    scan_idx_s = 2'b00;
    found_s    = 1'b0;
    if (fix_en) begin
      win_idx_s = sel_in;
      if (valid_s[sel_in]) begin
        grant_s[sel_in] = 1'b1;
      end else begin
        grant_s = 4'b0000;
      end
    end else begin
      for (int i = 1; i <= 4; i++) begin
        scan_idx_s = last_grant_r + 2'(i);
        if (!found_s && valid_s[scan_idx_s]) begin
          grant_s[scan_idx_s] = 1'b1;
          win_idx_s           = scan_idx_s;
          found_s             = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Data mux for the winning channel
  always_comb begin
    case (win_idx_s)
      2'd0:    win_data_s = ch_1;
      2'd1:    win_data_s = ch_2;
      2'd2:    win_data_s = ch_3;
      2'd3:    win_data_s = ch_4;
      default: win_data_s = '0;
    endcase
  end

  // Output-register FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: an accept always fills; a drain without accept empties
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else if (ch_out_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // FSM outputs: valid flag and per-channel readies
  always_comb begin
    ch_out_valid = (state_r == FULL);
    if (can_accept_s) begin
      ready_s = grant_s;
    end else begin
      ready_s = 4'b0000;
    end
    ch_1_ready = ready_s[0];
    ch_2_ready = ready_s[1];
    ch_3_ready = ready_s[2];
    ch_4_ready = ready_s[3];
  end

  // Beat payload, source tag and round-robin pointer; all hold unless a beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r       <= '0;
      sel_r        <= 2'b00;
      last_grant_r <= 2'b11;
    end else if (accept_s) begin
      data_r       <= win_data_s;
      sel_r        <= win_idx_s;
      last_grant_r <= win_idx_s;
    end else begin
      data_r       <= data_r;
      sel_r        <= sel_r;
      last_grant_r <= last_grant_r;
    end
  end

  assign ch_out  = data_r;
  assign sel_out = sel_r;

endmodule

// File: tb/tb_arb_mux_4to1_n.sv
// Directed plus randomized bench for arb_mux_4to1_n, checked against a
// cycle-level model of the arbitration rules and the single-entry output register.
module tb_arb_mux_4to1_n;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  d [4];
  logic [3:0]    v;
  logic [3:0]    rdy;
  logic          fix_en;
  logic [1:0]    sel_in;
  logic [W-1:0]  ch_out;
  logic          ch_out_valid;
  logic          ch_out_ready;
  logic [1:0]    sel_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_lg;
  bit           m_v;
  logic [W-1:0] m_data;
  int           m_sel;

  logic [W-1:0] rr_tab [4] = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
  int           rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  arb_mux_4to1_n #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_1(d[0]), .ch_1_valid(v[0]), .ch_1_ready(rdy[0]),
    .ch_2(d[1]), .ch_2_valid(v[1]), .ch_2_ready(rdy[1]),
    .ch_3(d[2]), .ch_3_valid(v[2]), .ch_3_ready(rdy[2]),
    .ch_4(d[3]), .ch_4_valid(v[3]), .ch_4_ready(rdy[3]),
    .fix_en(fix_en), .sel_in(sel_in),
    .ch_out(ch_out), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
    .sel_out(sel_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_lg   = 3;
    m_v    = 1'b0;
    m_data = '0;
    m_sel  = 0;
  endtask

  // Winning channel under the current inputs, or -1 when nobody is eligible
  function automatic int pick();
    if (fix_en) return v[sel_in] ? int'(sel_in) : -1;
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (m_lg + off) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check readies before the edge, advance model, check outputs after it
  task automatic step(input string tag);
    int         w;
    bit         can;
    logic [3:0] exp_rdy;
    #1;
    can     = !m_v || ch_out_ready;
    w       = pick();
    exp_rdy = 4'b0000;
    if (w >= 0 && can) exp_rdy[w] = 1'b1;
    chk({tag, "_ready"}, W'(rdy), W'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != 4'b0000) begin
      m_v    = 1'b1;
      m_data = d[w];
      m_sel  = w;
      m_lg   = w;
    end else if (m_v && ch_out_ready) begin
      m_v = 1'b0;
    end
    #1;
    chk({tag, "_valid"}, W'(ch_out_valid), W'(m_v));
    chk({tag, "_data"}, ch_out, m_data);
    chk({tag, "_sel"}, W'(sel_out), W'(m_sel));
  endtask

  initial begin
    rst_n        = 1'b0;
    v            = 4'b0000;
    fix_en       = 1'b0;
    sel_in       = 2'b00;
    ch_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    reset_model();
    #2;
    chk("rst_valid", W'(ch_out_valid), W'(1'b0));
    chk("rst_data", ch_out, '0);
    chk("rst_sel", W'(sel_out), W'(2'b00));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin over four continuously valid channels, starting at ch_1
    for (int k = 0; k < 4; k++) d[k] = rr_tab[k];
    v            = 4'b1111;
    ch_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      chk("rr_order_sel", W'(sel_out), W'(rr_exp[i]));
      chk("rr_order_data", ch_out, rr_tab[rr_exp[i]]);
    end

    // Single-channel streaming on ch_2, no bubbles
    v = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      d[1] = W'(8'h10 + i);
      step("stream");
      chk("stream_data", ch_out, W'(8'h10 + i));
      chk("stream_sel", W'(sel_out), W'(2'b01));
      chk("stream_valid", W'(ch_out_valid), W'(1'b1));
    end

    // Backpressure holds the beat, then the next grant follows the held source
    v            = 4'b0101;
    d[0]         = 64'h1111;
    d[2]         = 64'h3333;
    ch_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("bp");
      chk("bp_hold_data", ch_out, W'(8'h17));
      chk("bp_hold_sel", W'(sel_out), W'(2'b01));
      chk("bp_rdy_low", W'(rdy), W'(4'b0000));
    end
    ch_out_ready = 1'b1;
    step("bp_rel");
    chk("bp_next_sel", W'(sel_out), W'(2'b10));
    chk("bp_next_data", ch_out, 64'h3333);

    // Fixed mode on ch_3, then back to round-robin
    fix_en = 1'b1;
    sel_in = 2'b10;
    v      = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      d[2] = W'(16'h3000 + i);
      step("fix");
      chk("fix_rdy", W'(rdy), W'(4'b0100));
      chk("fix_sel", W'(sel_out), W'(2'b10));
    end
    fix_en = 1'b0;
    step("unfix");
    chk("unfix_sel", W'(sel_out), W'(2'b11));

    // Sparse alternating ch_4 / ch_1 with toggling downstream ready
    for (int i = 0; i < 12; i++) begin
      v            = (i % 2 == 0) ? 4'b1000 : 4'b0001;
      d[0]         = {$urandom(), $urandom()};
      d[3]         = {$urandom(), $urandom()};
      ch_out_ready = (i % 3 != 0);
      step("sparse");
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v            = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom()};
      fix_en       = ($urandom_range(0, 7) == 0);
      sel_in       = 2'($urandom_range(0, 3));
      ch_out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Asynchronous reset with a beat held
    fix_en       = 1'b0;
    v            = 4'b1111;
    ch_out_ready = 1'b0;
    step("pre_rst");
    chk("pre_rst_full", W'(ch_out_valid), W'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(ch_out_valid), W'(1'b0));
    chk("arst_data", ch_out, '0);
    chk("arst_sel", W'(sel_out), W'(2'b00));
    reset_model();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    ch_out_ready = 1'b1;
    step("post_rst");
    chk("post_rst_first", W'(sel_out), W'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
